// File: rtl/ghash_hkey_sched.sv
// ghash_hkey_sched
//   Derives the GHASH key powers H^2 and H^4 (and H^3 when GHASH_H3_EN is
//   defined) from hash key H by driving a shared GF(2^128) multiplier over a
//   start/done handshake. Published keys never change while the GHASH engine
//   reports busy; a key arriving then is parked until the engine goes idle.
//
//   Optional feature macro: GHASH_H3_EN (adds h3 output and ISSUE3/WAIT3).
//
//   Ports
//     clk, rst            clock (rising edge), asynchronous active-low reset
//     hkey_i, hkey_valid  new hash key H, one-cycle pulse
//     clear               synchronous: invalidate keys, zero them, clear error
//     ghash_busy          GHASH engine is consuming h1/h2/h4
//     mul_start           one-cycle multiplier request (high in ISSUE states)
//     mul_a, mul_b        multiplier operands, held from start until done
//     mul_done, mul_res   multiplier completion pulse and product
//     h1, h2, (h3,) h4    H, H^2, (H^3,) H^4
//     h_valid             key outputs valid and stable
//     sched_busy          scheduler working or holding a parked key
//     error_o             sticky multiplier timeout
module ghash_hkey_sched #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] hkey_i,
    input  logic         hkey_valid,
    input  logic         clear,
    input  logic         ghash_busy,
    output logic         mul_start,
    output logic [127:0] mul_a,
    output logic [127:0] mul_b,
    input  logic         mul_done,
    input  logic [127:0] mul_res,
    output logic [127:0] h1,
    output logic [127:0] h2,
`ifdef GHASH_H3_EN
    output logic [127:0] h3,
`endif
    output logic [127:0] h4,
    output logic         h_valid,
    output logic         sched_busy,
    output logic         error_o
);

    localparam int unsigned   CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_ISSUE1, S_WAIT1, S_ISSUE2, S_WAIT2,
`ifdef GHASH_H3_EN
        S_ISSUE3, S_WAIT3,
`endif
        S_READY, S_PEND, S_DRAIN, S_ERR
    } state_t;

    state_t        r_state, w_next, w_after_issue, w_after_wait;
    logic [CW-1:0] r_cnt, w_cnt_inc;
    logic [127:0]  r_h1, r_h2, r_h4, r_mul_a, r_mul_b, r_pend_key, w_key;
`ifdef GHASH_H3_EN
    logic [127:0]  r_h3;
`endif
    logic          r_pend, r_h_valid, r_sched_busy, r_error;
    logic          w_issue, w_wait_op, w_in_wait, w_tmo;
    logic          w_load, w_pend_wr, w_cap, w_err;

    // Per-state successors of the ISSUE/WAIT chain.
    always_comb begin
        w_issue       = 1'b0;
        w_wait_op     = 1'b0;
        w_after_issue = S_WAIT1;
        w_after_wait  = S_READY;
        case (r_state)
            S_ISSUE1: begin w_issue = 1'b1; w_after_issue = S_WAIT1; end
            S_ISSUE2: begin w_issue = 1'b1; w_after_issue = S_WAIT2; end
            S_WAIT1:  begin w_wait_op = 1'b1; w_after_wait = S_ISSUE2; end
            S_WAIT2: begin
                w_wait_op = 1'b1;
`ifdef GHASH_H3_EN
                w_after_wait = S_ISSUE3;
`endif
            end
`ifdef GHASH_H3_EN
            S_ISSUE3: begin w_issue = 1'b1; w_after_issue = S_WAIT3; end
            S_WAIT3:  begin w_wait_op = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign w_in_wait = w_wait_op || (r_state == S_DRAIN);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_tmo     = (w_cnt_inc == TMO);

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_key     = hkey_i;
        w_pend_wr = 1'b0;
        w_cap     = 1'b0;
        w_err     = 1'b0;
        if (clear) begin
            w_next = S_IDLE;
        end else if (w_issue) begin
            // mul_start is already out this cycle, so a new key must wait for that op in DRAIN.
            if (hkey_valid) begin
                w_pend_wr = 1'b1;
                w_next    = S_DRAIN;
            end else begin
                w_next = w_after_issue;
            end
        end else if (w_wait_op) begin
            if (mul_done) begin
                if (hkey_valid) begin
                    // Product belongs to the superseded key: drop it and restart.
                    w_load = 1'b1;
                    w_next = S_ISSUE1;
                end else begin
                    w_cap  = 1'b1;
                    w_next = w_after_wait;
                end
            end else if (w_tmo) begin
                w_err  = 1'b1;
                w_next = S_ERR;
            end else if (hkey_valid) begin
                w_pend_wr = 1'b1;
                w_next    = S_DRAIN;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (hkey_valid) begin
                        w_load = 1'b1;
                        w_next = S_ISSUE1;
                    end
                end
                S_READY: begin
                    if (hkey_valid) begin
                        if (ghash_busy) begin
                            w_pend_wr = 1'b1;
                            w_next    = S_PEND;
                        end else begin
                            w_load = 1'b1;
                            w_next = S_ISSUE1;
                        end
                    end
                end
                S_PEND: begin
                    w_pend_wr = hkey_valid;
                    if (!ghash_busy) begin
                        w_load = 1'b1;
                        w_key  = hkey_valid ? hkey_i : r_pend_key;
                        w_next = S_ISSUE1;
                    end
                end
                S_DRAIN: begin
                    if (mul_done) begin
                        if (hkey_valid || r_pend) begin
                            w_load = 1'b1;
                            w_key  = hkey_valid ? hkey_i : r_pend_key;
                            w_next = S_ISSUE1;
                        end else begin
                            w_next = S_IDLE;
                        end
                    end else if (w_tmo) begin
                        w_err  = 1'b1;
                        w_next = S_ERR;
                    end else if (hkey_valid) begin
                        w_pend_wr = 1'b1;
                    end
                end
                default: ; // S_ERR is left only through clear or reset
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Counter restarts on every entry into a wait state and runs while there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              r_cnt <= '0;
        else if (w_in_wait && w_next == r_state) r_cnt <= w_cnt_inc;
        else                                   r_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h1 <= '0; r_h2 <= '0; r_h4 <= '0;
`ifdef GHASH_H3_EN
            r_h3 <= '0;
`endif
            r_mul_a <= '0; r_mul_b <= '0; r_pend_key <= '0; r_pend <= 1'b0;
        end else if (clear) begin
            r_h1 <= '0; r_h2 <= '0; r_h4 <= '0;
`ifdef GHASH_H3_EN
            r_h3 <= '0;
`endif
            r_mul_a <= '0; r_mul_b <= '0; r_pend_key <= '0; r_pend <= 1'b0;
        end else begin
            if (w_pend_wr) begin
                r_pend_key <= hkey_i;
                r_pend     <= 1'b1;
            end
            if (w_load) begin
                r_h1    <= w_key;
                r_mul_a <= w_key;
                r_mul_b <= w_key;
                r_pend  <= 1'b0;
            end
            if (w_cap) begin
                case (r_state)
                    S_WAIT1: begin
                        r_h2    <= mul_res;
                        r_mul_a <= mul_res;
                        r_mul_b <= mul_res;
                    end
                    S_WAIT2: begin
                        r_h4 <= mul_res;
`ifdef GHASH_H3_EN
                        r_mul_a <= r_h2;
                        r_mul_b <= r_h1;
`endif
                    end
`ifdef GHASH_H3_EN
                    S_WAIT3: r_h3 <= mul_res;
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h_valid    <= 1'b0;
            r_sched_busy <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_h_valid    <= (w_next == S_READY) || (w_next == S_PEND);
            r_sched_busy <= !((w_next == S_IDLE) || (w_next == S_READY) || (w_next == S_ERR));
            if (clear)      r_error <= 1'b0;
            else if (w_err) r_error <= 1'b1;
        end
    end

    assign mul_start  = w_issue;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign h1         = r_h1;
    assign h2         = r_h2;
`ifdef GHASH_H3_EN
    assign h3         = r_h3;
`endif
    assign h4         = r_h4;
    assign h_valid    = r_h_valid;
    assign sched_busy = r_sched_busy;
    assign error_o    = r_error;

endmodule

// File: tb/tb_ghash_hkey_sched.sv
module tb_ghash_hkey_sched;
    localparam int TO = 64;
`ifdef GHASH_H3_EN
    localparam int NMUL = 3;
`else
    localparam int NMUL = 2;
`endif

    typedef struct packed {
        logic [127:0] h1, h2, h3, h4;
    } keyset_t;

    logic         clk, rst, hkey_valid, clear, ghash_busy, mul_start, mul_done;
    logic [127:0] hkey_i, mul_a, mul_b, mul_res, h1, h2, h4, h3_w;
    logic         h_valid, sched_busy, error_o;

    ghash_hkey_sched #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .hkey_i(hkey_i), .hkey_valid(hkey_valid),
        .clear(clear), .ghash_busy(ghash_busy), .mul_start(mul_start),
        .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_res(mul_res),
        .h1(h1), .h2(h2),
`ifdef GHASH_H3_EN
        .h3(h3_w),
`endif
        .h4(h4), .h_valid(h_valid), .sched_busy(sched_busy), .error_o(error_o)
    );
`ifndef GHASH_H3_EN
    assign h3_w = '0;
`endif

    int n_vec = 0, n_err = 0;
    int cyc = 0, c0 = 0, hv_cyc = -1, err_cyc = -1;
    int L = 4;
    bit stall = 0;
    int start_q[$];
    logic [255:0] exp_ops[$];
    keyset_t exp_keys[$];
    logic [127:0] m_h1 = '0, m_h2 = '0;

    // GF(2^128) product in GCM bit order (bit 0 of the field element is the MSB).
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z, v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z ^= v;
            if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
            else      v = v >> 1;
        end
        return z;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int nom(input int l);
`ifdef GHASH_H3_EN
        return 4 + 3 * l;
`else
        return 3 + 2 * l;
`endif
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, "_start"}, mul_start, 1'b0);
        chk ({tag, "_mul_a"}, mul_a, '0);
        chk ({tag, "_mul_b"}, mul_b, '0);
        chk ({tag, "_h1"}, h1, '0);
        chk ({tag, "_h2"}, h2, '0);
        chk ({tag, "_h4"}, h4, '0);
        chk ({tag, "_h3"}, h3_w, '0);
        chk1({tag, "_h_valid"}, h_valid, 1'b0);
        chk1({tag, "_sched_busy"}, sched_busy, 1'b0);
        chk1({tag, "_error"}, error_o, 1'b0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_key(input logic [127:0] k);
        hkey_i = k;
        hkey_valid = 1'b1;
        c0 = cyc;
        tick(1);
        hkey_valid = 1'b0;
        hkey_i = rand128();
    endtask

    // Reference: expected multiplier requests and the published key set for key k.
    task automatic push_exp(input logic [127:0] k);
        keyset_t ks;
        ks.h1 = k;
        ks.h2 = gf_mul(k, k);
        ks.h4 = gf_mul(ks.h2, ks.h2);
`ifdef GHASH_H3_EN
        ks.h3 = gf_mul(ks.h2, k);
`else
        ks.h3 = '0;
`endif
        exp_ops.push_back({k, k});
        exp_ops.push_back({ks.h2, ks.h2});
`ifdef GHASH_H3_EN
        exp_ops.push_back({ks.h2, k});
`endif
        exp_keys.push_back(ks);
        m_h1 = k;
        m_h2 = ks.h2;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Multiplier model with latency L; junk on mul_res whenever mul_done is low.
    initial begin
        logic [127:0] ma, mb;
        int m_cnt;
        m_cnt = 0;
        ma = '0;
        mb = '0;
        mul_done = 1'b0;
        mul_res = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            mul_res = rand128();
            if (!rst) begin
                m_cnt = 0;
            end else begin
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0 && !stall) begin
                        mul_done = 1'b1;
                        mul_res = gf_mul(ma, mb);
                        chk("hold_a", mul_a, ma);
                        chk("hold_b", mul_b, mb);
                    end
                end
                if (mul_start) begin
                    ma = mul_a;
                    mb = mul_b;
                    m_cnt = L;
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic prev_hv, prev_err;
        logic [255:0] op;
        keyset_t ks;
        prev_hv = 1'b0;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mul_start) begin
                    start_q.push_back(cyc);
                    if (exp_ops.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL op_unexpected: got a=0x%0h b=0x%0h, required no request", mul_a, mul_b);
                    end else begin
                        op = exp_ops.pop_front();
                        chk("op_a", mul_a, op[255:128]);
                        chk("op_b", mul_b, op[127:0]);
                    end
                end
                if (h_valid && !prev_hv) begin
                    hv_cyc = cyc;
                    if (exp_keys.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL hv_unexpected: got h_valid rise at cycle %0d, required none", cyc);
                    end else begin
                        ks = exp_keys.pop_front();
                        chk("sb_h1", h1, ks.h1);
                        chk("sb_h2", h2, ks.h2);
                        chk("sb_h4", h4, ks.h4);
                        chk("sb_h3", h3_w, ks.h3);
                    end
                end
                if (error_o && !prev_err) err_cyc = cyc;
            end
            prev_hv = h_valid;
            prev_err = error_o;
        end
    end

    task automatic run_nominal(input logic [127:0] k, input int l);
        L = l;
        start_q.delete();
        hv_cyc = -1;
        push_exp(k);
        apply_key(k);
        chk1("nom_hv_drop", h_valid, 1'b0);
        chk1("nom_busy", sched_busy, 1'b1);
        tick(nom(l) + 2);
        chk_int("nom_hv_time", hv_cyc - c0, nom(l));
        chk_int("nom_nstart", start_q.size(), NMUL);
        if (start_q.size() >= 2) begin
            chk_int("nom_start1", start_q[0] - c0, 1);
            chk_int("nom_start2", start_q[1] - c0, 2 + l);
        end
        chk1("nom_ready_busy", sched_busy, 1'b0);
    endtask

    initial begin
        logic [127:0] k1, k2, last, old2;
        int d, off, base, np;
        rst = 1'b0;
        hkey_i = '0;
        hkey_valid = 1'b0;
        clear = 1'b0;
        ghash_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        tick(2);
        chk_zero("idle");

        // Known key, L=4, then random keys re-keyed straight from READY.
        run_nominal(128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 4);
        for (int i = 0; i < 3; i++) run_nominal(rand128(), $urandom_range(1, 6));

        // New key while GHASH busy: parked, outputs frozen until busy drops.
        for (int i = 0; i < 2; i++) begin
            L = $urandom_range(1, 5);
            start_q.delete();
            hv_cyc = -1;
            ghash_busy = 1'b1;
            np = i + 1;
            last = '0;
            for (int p = 0; p < np; p++) begin
                last = rand128();
                apply_key(last);
                chk1("pend_hv", h_valid, 1'b1);
                chk("pend_h1", h1, m_h1);
                chk1("pend_busy", sched_busy, 1'b1);
                tick(2);
            end
            push_exp(last);
            ghash_busy = 1'b0;
            d = cyc;
            tick(1);
            chk1("pend_hv_drop", h_valid, 1'b0);
            chk("pend_load_h1", h1, last);
            tick(nom(L) + 2);
            chk_int("pend_hv_time", hv_cyc - d, nom(L));
            chk_int("pend_nstart", start_q.size(), NMUL);
        end

        // New key while the first product is outstanding.
        for (int i = 0; i < 4; i++) begin
            L = (i == 0) ? 4 : $urandom_range(1, 5);
            off = (i == 0) ? 3 : $urandom_range(1, L + 1);
            k1 = rand128();
            k2 = rand128();
            old2 = m_h2;
            start_q.delete();
            hv_cyc = -1;
            exp_ops.push_back({k1, k1});
            push_exp(k2);
            apply_key(k1);
            base = c0;
            if (off > 1) tick(off - 1);
            hkey_i = k2;
            hkey_valid = 1'b1;
            tick(1);
            hkey_valid = 1'b0;
            if (cyc < base + 2 + L) tick(base + 2 + L - cyc);
            chk("abort_h2_kept", h2, old2);
            chk("abort_h1_new", h1, k2);
            tick(nom(L) + 2);
            chk_int("abort_hv_time", hv_cyc - base, 1 + L + nom(L));
            chk_int("abort_nstart", start_q.size(), NMUL + 1);
            if (start_q.size() >= 2) chk_int("abort_restart", start_q[1] - base, 2 + L);
        end

        // clear together with a new key in READY.
        start_q.delete();
        hkey_i = rand128();
        hkey_valid = 1'b1;
        clear = 1'b1;
        tick(1);
        hkey_valid = 1'b0;
        clear = 1'b0;
        chk_zero("clr_key");
        tick(10);
        chk_int("clr_nstart", start_q.size(), 0);
        m_h1 = '0;
        m_h2 = '0;

        // Multiplier never answers.
        stall = 1;
        L = 4;
        err_cyc = -1;
        start_q.delete();
        k1 = rand128();
        exp_ops.push_back({k1, k1});
        apply_key(k1);
        tick(TO + 4);
        chk_int("tmo_time", err_cyc - c0, TO + 2);
        chk1("tmo_err", error_o, 1'b1);
        chk1("tmo_hv", h_valid, 1'b0);
        chk1("tmo_busy", sched_busy, 1'b0);
        hkey_i = rand128();
        hkey_valid = 1'b1;
        tick(1);
        hkey_valid = 1'b0;
        tick(4);
        chk_int("err_nstart", start_q.size(), 1);
        chk1("err_sticky", error_o, 1'b1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        stall = 0;
        chk_zero("err_clear");
        tick(2);
        run_nominal(rand128(), 3);

        chk_int("ops_left", exp_ops.size(), 0);
        chk_int("keys_left", exp_keys.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
